reboot_req_ctrl: RTL and testbench

REBOOT_REQ_CTRL -- requirements
Module: reboot_req_ctrl

---
 rtl/reboot_req_ctrl_pkg.sv | 12 +
 rtl/reboot_wdt.sv | 22 ++
 rtl/reboot_req_ctrl.sv | 101 ++++++++++
 tb/tb_reboot_req_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/reboot_req_ctrl_pkg.sv
// reboot_req_ctrl_pkg: state encoding and default unlock key shared by the reboot request controller.
package reboot_req_ctrl_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_COUNT = 3'd2;
  localparam logic [2:0] S_FIRE  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [31:0] DEFAULT_KEY = 32'h5EB0_07A5;
  function automatic logic is_busy(input logic [2:0] s);
    return s == S_ARMED || s == S_COUNT || s == S_FIRE;
  endfunction
endpackage

// File: rtl/reboot_wdt.sv
// reboot_wdt: watchdog down-counter; reloads on kick, counts only while run is high, sticky fired flag.
module reboot_wdt #(
  parameter logic [31:0] WDT_CYCLES = 32'h4000_0000
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic kick,
  input  logic run,
  output logic expire,
  output logic fired
);
  logic [31:0] cnt;
  assign expire = run && !kick && cnt == 32'd1;
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) begin
      cnt   <= WDT_CYCLES;
      fired <= 1'b0;
    end else begin
      cnt   <= (kick || expire) ? WDT_CYCLES : run ? cnt - 32'd1 : cnt;
      fired <= fired | expire;
    end
endmodule

// File: rtl/reboot_req_ctrl.sv
// reboot_req_ctrl: KEY/~KEY unlocked reboot request with countdown and fixed-width reboot pulse.
// Optional watchdog path enabled by defining REBOOT_WATCHDOG_EN.
module reboot_req_ctrl
  import reboot_req_ctrl_pkg::*;
#(
  parameter logic [31:0] KEY          = DEFAULT_KEY,
  parameter logic [31:0] ARM_TIMEOUT  = 32'd1024,
  parameter logic [31:0] DELAY_CYCLES = 32'd1000000,
  parameter logic [7:0]  HOLD_CYCLES  = 8'd8,
  parameter logic [31:0] WDT_CYCLES   = 32'h4000_0000
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_key,
  input  logic        cancel,
  input  logic        wdt_kick,
  output logic        reboot,
  output logic        busy,
  output logic        armed,
  output logic        err,
  output logic [31:0] remain,
  output logic        wdt_fired
);
  logic [2:0]  state;
  logic [31:0] arm_tmr;
  logic [7:0]  hold;
  logic        wdt_exp;
`ifdef REBOOT_WATCHDOG_EN
  reboot_wdt #(.WDT_CYCLES(WDT_CYCLES)) u_wdt (
    .sys_clk(sys_clk),
    .rst(rst),
    .kick(wdt_kick),
    .run(state == S_IDLE || state == S_ARMED),
    .expire(wdt_exp),
    .fired(wdt_fired)
  );
`else
  logic unused_wdt;
  assign unused_wdt = wdt_kick | (WDT_CYCLES == 32'd0);
  assign wdt_exp    = 1'b0;
  assign wdt_fired  = 1'b0;
`endif
  assign busy  = is_busy(state);
  assign armed = state == S_ARMED;
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) begin
      state   <= S_IDLE;
      arm_tmr <= '0;
      remain  <= '0;
      hold    <= '0;
      reboot  <= 1'b0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      if (wdt_exp) begin
        state  <= S_FIRE;
        remain <= '0;
        hold   <= '0;
      end else begin
        case (state)
          S_IDLE:
            if (req_valid) begin
              if (req_key == KEY) begin
                state   <= S_ARMED;
                arm_tmr <= ARM_TIMEOUT;
              end else err <= 1'b1;
            end
          S_ARMED:
            if (cancel) state <= S_IDLE;
            else if (req_valid) begin
              state  <= (req_key == ~KEY) ? S_COUNT : S_IDLE;
              remain <= (req_key == ~KEY) ? DELAY_CYCLES : '0;
              err    <= req_key != ~KEY;
            end else if (arm_tmr == 32'd1) begin
              state <= S_IDLE;
              err   <= 1'b1;
            end else arm_tmr <= arm_tmr - 32'd1;
          S_COUNT:
            if (cancel) begin
              state  <= S_IDLE;
              remain <= '0;
            end else if (remain == 32'd1) begin
              state  <= S_FIRE;
              remain <= '0;
              hold   <= '0;
            end else remain <= remain - 32'd1;
          // reboot rises one cycle after FIRE entry and stays for HOLD_CYCLES cycles
          S_FIRE:
            if (hold == HOLD_CYCLES) begin
              state  <= S_DONE;
              reboot <= 1'b0;
            end else begin
              reboot <= 1'b1;
              hold   <= hold + 8'd1;
            end
          default: reboot <= 1'b0;
        endcase
      end
    end
endmodule

// File: tb/tb_reboot_req_ctrl.sv
// tb_reboot_req_ctrl: table-driven and sequence checks with an expected-output scoreboard queue.
module tb_reboot_req_ctrl;
  import reboot_req_ctrl_pkg::*;
  localparam logic [31:0] K   = DEFAULT_KEY;
  localparam logic [31:0] BAD = 32'h1234_5678;
  typedef struct packed {
    logic        reboot;
    logic        busy;
    logic        armed;
    logic        err;
    logic [31:0] remain;
    logic        wdt_fired;
  } outs_t;
  typedef struct packed {
    logic        v;
    logic [31:0] k;
    logic        c;
    outs_t       e;
  } vec_t;
  logic sys_clk = 1'b0;
  logic rst = 1'b1, req_valid = 1'b0, cancel = 1'b0, wdt_kick = 1'b1;
  logic [31:0] req_key = '0;
  logic reboot, busy, armed, err, wdt_fired;
  logic [31:0] remain;
  outs_t sb[$];
  vec_t tbl[11];
  int checks = 0, errors = 0;
  always #5 sys_clk = ~sys_clk;
  reboot_req_ctrl #(
    .ARM_TIMEOUT(32'd16),
    .DELAY_CYCLES(32'd10),
    .HOLD_CYCLES(8'd8),
    .WDT_CYCLES(32'd100)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .req_valid(req_valid), .req_key(req_key),
    .cancel(cancel), .wdt_kick(wdt_kick), .reboot(reboot), .busy(busy),
    .armed(armed), .err(err), .remain(remain), .wdt_fired(wdt_fired)
  );
  function automatic outs_t o(input logic rb, input logic b, input logic a, input logic e,
                              input logic [31:0] r, input logic w);
    outs_t x;
    x = '{reboot: rb, busy: b, armed: a, err: e, remain: r, wdt_fired: w};
    return x;
  endfunction
  task automatic cmp(input string name);
    outs_t got, exp;
    got = '{reboot: reboot, busy: busy, armed: armed, err: err, remain: remain, wdt_fired: wdt_fired};
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got reboot=%b busy=%b armed=%b err=%b remain=%0d wdt_fired=%b, expected reboot=%b busy=%b armed=%b err=%b remain=%0d wdt_fired=%b",
               name, got.reboot, got.busy, got.armed, got.err, got.remain, got.wdt_fired,
               exp.reboot, exp.busy, exp.armed, exp.err, exp.remain, exp.wdt_fired);
    end
  endtask
  task automatic step(input string name, input logic v, input logic [31:0] k, input logic c, input outs_t e);
    req_valid = v;
    req_key   = k;
    cancel    = c;
    sb.push_back(e);
    @(posedge sys_clk);
    #1;
    cmp(name);
  endtask
  task automatic do_reset(input string name);
    rst = 1'b1;
    req_valid = 1'b0;
    cancel = 1'b0;
    req_key = '0;
    @(posedge sys_clk);
    #1;
    sb.push_back(o(0, 0, 0, 0, 0, 0));
    cmp(name);
    rst = 1'b0;
  endtask
  initial begin
    tbl[0]  = '{1'b1, BAD, 1'b0, o(0, 0, 0, 1, 0, 0)};
    tbl[1]  = '{1'b0, 32'd0, 1'b0, o(0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{1'b1, K, 1'b0, o(0, 1, 1, 0, 0, 0)};
    tbl[3]  = '{1'b1, BAD, 1'b0, o(0, 0, 0, 1, 0, 0)};
    tbl[4]  = '{1'b1, K, 1'b0, o(0, 1, 1, 0, 0, 0)};
    tbl[5]  = '{1'b1, ~K, 1'b1, o(0, 0, 0, 0, 0, 0)};
    tbl[6]  = '{1'b1, K, 1'b0, o(0, 1, 1, 0, 0, 0)};
    tbl[7]  = '{1'b1, ~K, 1'b0, o(0, 1, 0, 0, 10, 0)};
    tbl[8]  = '{1'b0, 32'd0, 1'b0, o(0, 1, 0, 0, 9, 0)};
    tbl[9]  = '{1'b1, K, 1'b0, o(0, 1, 0, 0, 8, 0)};
    tbl[10] = '{1'b0, 32'd0, 1'b1, o(0, 0, 0, 0, 0, 0)};
    do_reset("reset_state");
    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i].v, tbl[i].k, tbl[i].c, tbl[i].e);
    // full reboot: remain 10..1, FIRE at 11, reboot 12..19, DONE from 20
    do_reset("a_reset");
    step("a_key", 1, K, 0, o(0, 1, 1, 0, 0, 0));
    step("a_conf", 1, ~K, 0, o(0, 1, 0, 0, 10, 0));
    for (int n = 2; n <= 21; n++)
      step($sformatf("a_cyc%0d", n), 0, 32'd0, 0,
           o(n >= 12 && n <= 19, n <= 19, 0, 0, n <= 10 ? 32'(11 - n) : 32'd0, 0));
    step("done_key", 1, K, 0, o(0, 0, 0, 0, 0, 0));
    step("done_bad", 1, BAD, 0, o(0, 0, 0, 0, 0, 0));
    step("done_cancel", 1, ~K, 1, o(0, 0, 0, 0, 0, 0));
    // arm timeout: armed for 16 cycles, err with the fall
    do_reset("b_reset");
    step("b_key", 1, K, 0, o(0, 1, 1, 0, 0, 0));
    for (int n = 2; n <= 18; n++)
      step($sformatf("b_cyc%0d", n), 0, 32'd0, 0, o(0, n <= 16, n <= 16, n == 17, 0, 0));
    // cancel at remain=5 with a simultaneous request
    do_reset("c_reset");
    step("c_key", 1, K, 0, o(0, 1, 1, 0, 0, 0));
    step("c_conf", 1, ~K, 0, o(0, 1, 0, 0, 10, 0));
    for (int n = 2; n <= 6; n++)
      step($sformatf("c_cyc%0d", n), 0, 32'd0, 0, o(0, 1, 0, 0, 32'(11 - n), 0));
    step("c_cancel", 1, K, 1, o(0, 0, 0, 0, 0, 0));
    for (int n = 0; n < 3; n++) step($sformatf("c_after%0d", n), 0, 32'd0, 0, o(0, 0, 0, 0, 0, 0));
    // asynchronous reset during the 3rd FIRE cycle
    do_reset("d_reset");
    step("d_key", 1, K, 0, o(0, 1, 1, 0, 0, 0));
    step("d_conf", 1, ~K, 0, o(0, 1, 0, 0, 10, 0));
    for (int n = 2; n <= 13; n++)
      step($sformatf("d_cyc%0d", n), 0, 32'd0, 0,
           o(n >= 12, 1, 0, 0, n <= 10 ? 32'(11 - n) : 32'd0, 0));
    req_valid = 1'b0;
    cancel = 1'b0;
    #2 rst = 1'b1;
    #1;
    sb.push_back(o(0, 0, 0, 0, 0, 0));
    cmp("d_async_rst");
    @(posedge sys_clk);
    #1 rst = 1'b0;
    for (int n = 0; n < 12; n++) step($sformatf("d_after%0d", n), 0, 32'd0, 0, o(0, 0, 0, 0, 0, 0));
    step("d_rearm", 1, K, 0, o(0, 1, 1, 0, 0, 0));
    // watchdog: no kicks
    wdt_kick = 1'b0;
    do_reset("e_reset");
`ifdef REBOOT_WATCHDOG_EN
    for (int n = 1; n <= 110; n++)
      step($sformatf("e_cyc%0d", n), 0, 32'd0, 0,
           o(n >= 101 && n <= 108, n >= 100 && n <= 108, 0, 0, 0, n >= 100));
`else
    for (int n = 1; n <= 20; n++)
      step($sformatf("e_cyc%0d", n), 0, 32'd0, 0, o(0, 0, 0, 0, 0, 0));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
